memoria_dados_multiprog: RTL and testbench

//  Partitioned data memory for the multiprogram core: NUM_PROGS+1 equal partitions (0 = kernel, 1..NUM_PROGS = user).

---
 rtl/memoria_dados_multiprog.sv | 200 ++++++++++++++++++++
 tb/tb_memoria_dados_multiprog.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memoria_dados_multiprog.sv
// Partitioned data memory with per-program bookkeeping (current slot, active mask, saved PC, round-robin).
// Optional macro PARTITION_GUARD_EN: rejects accesses whose in-partition offset reaches PART_DEPTH.
module memoria_dados_multiprog #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PROGS  = 4,
    parameter int PART_DEPTH = 200,
    parameter int CTX_WORDS  = 32,
    parameter int PID_W      = $clog2(NUM_PROGS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] endereco_leitura,
    input  logic [ADDR_WIDTH-1:0] endereco_escrita,
    input  logic                  we,
    input  logic                  offset_register,
    input  logic                  spc,
    input  logic [DATA_WIDTH-1:0] enderecoSpc,
    input  logic                  lpc,
    input  logic                  start_program,
    input  logic [PID_W-1:0]      prog_id,
    input  logic                  next_program,
    input  logic                  end_program,
    output logic [DATA_WIDTH-1:0] q,
    output logic [PID_W-1:0]      cur_program,
    output logic [PID_W-1:0]      active_count,
    output logic                  busy,
    output logic                  fault
);

    localparam int TOTAL = (NUM_PROGS + 1) * PART_DEPTH;
    localparam int AW    = $clog2(TOTAL);
    localparam int IDX_W = AW + 1;
    localparam int OFF_W = ADDR_WIDTH + 1;
`ifdef PARTITION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_CLR_CTX, S_RESCHED} state_t;

    state_t                state_q, state_d;
    logic [PID_W-1:0]      cur_q, cur_d;
    logic [NUM_PROGS:1]    mask_q, mask_d;
    logic [PID_W-1:0]      count_q, count_d;
    logic [PID_W-1:0]      clr_pid_q, clr_pid_d;
    logic                  resched_q, resched_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] q_q;
    logic                  cmd_fault;
    logic                  idle, clr_active;

    logic [DATA_WIDTH-1:0] mem [0:TOTAL-1];

    // First active slot after cur, ascending with wrap; cur itself is the last candidate.
    function automatic logic [PID_W-1:0] next_slot(input logic [PID_W-1:0] cur,
                                                   input logic [NUM_PROGS:1] m);
        logic [PID_W-1:0] r;
        logic [PID_W:0]   c;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_PROGS; k++) begin
            c = {1'b0, cur} + (PID_W+1)'(k);
            if (c > (PID_W+1)'(NUM_PROGS)) c = c - (PID_W+1)'(NUM_PROGS);
            if (!found && m[c]) begin
                r     = c[PID_W-1:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        mask_d    = mask_q;
        count_d   = count_q;
        clr_pid_d = clr_pid_q;
        resched_d = resched_q;
        cmd_fault = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (end_program) begin
                    if (cur_q == '0) begin
                        cmd_fault = 1'b1;
                    end else begin
                        mask_d[cur_q] = 1'b0;
                        count_d       = count_q - 1'b1;
                        clr_pid_d     = cur_q;
                        resched_d     = 1'b1;
                        state_d       = S_CLR_CTX;
                    end
                end else if (start_program) begin
                    if (prog_id == '0 || prog_id > PID_W'(NUM_PROGS)) begin
                        cmd_fault = 1'b1;
                    end else if (!mask_q[prog_id]) begin
                        mask_d[prog_id] = 1'b1;
                        count_d         = count_q + 1'b1;
                        clr_pid_d       = prog_id;
                        resched_d       = 1'b0;
                        state_d         = S_CLR_CTX;
                    end
                end else if (next_program) begin
                    cur_d = next_slot(cur_q, mask_q);
                end
            end
            S_CLR_CTX: state_d = resched_q ? S_RESCHED : S_IDLE;
            S_RESCHED: begin
                cur_d   = next_slot(cur_q, mask_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idle       = (state_q == S_IDLE);
        clr_active = (state_q == S_CLR_CTX);
        busy       = !idle;
    end

    // Address generation; offsets kept at full width so the guard sees untruncated values.
    logic [OFF_W-1:0]      w_off, r_off;
    logic                  w_oob, r_oob;
    logic [IDX_W-1:0]      cur_base, clr_base, w_idx, r_idx;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  acc_fault;

    always_comb begin
        w_off    = (offset_register ? '0 : OFF_W'(CTX_WORDS)) + {1'b0, endereco_escrita};
        r_off    = (offset_register | spc) ? {1'b0, endereco_leitura}
                                           : OFF_W'(CTX_WORDS) + {1'b0, endereco_leitura};
        if (lpc) r_off = '0;
        w_oob    = GUARD && (w_off >= OFF_W'(PART_DEPTH));
        r_oob    = GUARD && (r_off >= OFF_W'(PART_DEPTH));
        cur_base = IDX_W'(cur_q) * IDX_W'(PART_DEPTH);
        clr_base = IDX_W'(clr_pid_q) * IDX_W'(PART_DEPTH);
        w_idx    = cur_base + IDX_W'(w_off);
        r_idx    = cur_base + IDX_W'(r_off);

        wr_en     = 1'b0;
        wr_idx    = w_idx;
        wr_data   = data;
        acc_fault = r_oob;
        if (clr_active) begin
            wr_en   = 1'b1;
            wr_idx  = clr_base;
            wr_data = '0;
        end else if (idle && spc) begin
            wr_en   = 1'b1;
            wr_idx  = cur_base;
            wr_data = enderecoSpc;
        end else if (idle && we) begin
            wr_en     = !w_oob;
            acc_fault = r_oob | w_oob;
        end
        fault_d = cmd_fault | acc_fault;
    end

    always_ff @(posedge clock) begin
        if (wr_en && wr_idx < IDX_W'(TOTAL)) mem[wr_idx[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_q     <= '0;
            mask_q    <= '0;
            count_q   <= '0;
            clr_pid_q <= '0;
            resched_q <= 1'b0;
            fault_q   <= 1'b0;
            q_q       <= '0;
        end else begin
            cur_q     <= cur_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            clr_pid_q <= clr_pid_d;
            resched_q <= resched_d;
            fault_q   <= fault_d;
            if (r_oob || r_idx >= IDX_W'(TOTAL)) q_q <= '0;
            else                                 q_q <= mem[r_idx[AW-1:0]];
        end
    end

    assign q            = q_q;
    assign cur_program  = cur_q;
    assign active_count = count_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_memoria_dados_multiprog.sv
// Directed bench for memoria_dados_multiprog: slot bookkeeping, partitioned read/write, saved PC, guard.
module tb_memoria_dados_multiprog;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data, endereco_leitura, endereco_escrita, enderecoSpc;
    logic        we, offset_register, spc, lpc, start_program, next_program, end_program;
    logic [2:0]  prog_id;
    logic [31:0] q;
    logic [2:0]  cur_program, active_count;
    logic        busy, fault;

    int checks   = 0;
    int failures = 0;

    memoria_dados_multiprog dut (
        .clock(clock), .reset(reset), .data(data),
        .endereco_leitura(endereco_leitura), .endereco_escrita(endereco_escrita),
        .we(we), .offset_register(offset_register), .spc(spc), .enderecoSpc(enderecoSpc),
        .lpc(lpc), .start_program(start_program), .prog_id(prog_id),
        .next_program(next_program), .end_program(end_program),
        .q(q), .cur_program(cur_program), .active_count(active_count),
        .busy(busy), .fault(fault)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        we = 0; offset_register = 0; spc = 0; lpc = 0;
        start_program = 0; next_program = 0; end_program = 0;
        data = 0; enderecoSpc = 0; prog_id = 0;
        endereco_leitura = 0; endereco_escrita = 0;
    endtask

    // Pulse one command for a cycle, then let the bookkeeping FSM settle.
    task automatic do_start(input logic [2:0] id);
        start_program = 1; prog_id = id; tick(); clr_in(); tick();
    endtask

    task automatic do_next();
        next_program = 1; tick(); clr_in();
    endtask

    task automatic do_spc(input logic [31:0] pc);
        spc = 1; enderecoSpc = pc; tick(); clr_in();
    endtask

    initial begin
        clr_in();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        check("rst_q", q, 0);
        check("rst_cur", 32'(cur_program), 0);
        check("rst_cnt", 32'(active_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fault", 32'(fault), 0);

        // Slot 2: start, enter, save PC, end, restart -> saved PC cleared
        start_program = 1; prog_id = 2; tick(); clr_in();
        check("start_busy", 32'(busy), 1);
        check("start_cnt", 32'(active_count), 1);
        tick();
        check("start_done", 32'(busy), 0);
        do_next();
        check("next_to2", 32'(cur_program), 2);
        do_spc(32'h77);
        lpc = 1; tick(); clr_in();
        check("lpc_77", q, 32'h77);
        end_program = 1; tick(); clr_in();
        check("end2_busy", 32'(busy), 1);
        check("end2_cnt", 32'(active_count), 0);
        tick(); tick();
        check("end2_cur", 32'(cur_program), 0);
        check("end2_clr", dut.mem[400], 0);
        do_start(2);
        do_next();
        lpc = 1; tick(); clr_in();
        check("lpc_clr", q, 0);

        // Write/read in partition 2 data area
        we = 1; endereco_escrita = 5; data = 32'hA5; tick(); clr_in();
        endereco_leitura = 5; tick();
        check("rd_a5", q, 32'hA5);
        check("mem437", dut.mem[437], 32'hA5);
        we = 1; endereco_escrita = 5; data = 32'h5A; endereco_leitura = 5; tick();
        check("rw_old", q, 32'hA5);
        we = 0; tick();
        check("rw_new", q, 32'h5A);
        offset_register = 1; endereco_leitura = 37; tick(); clr_in();
        check("ctx_alias", q, 32'h5A);

        // Slots 1 and 3, command errors
        do_start(1);
        do_start(3);
        check("cnt3", 32'(active_count), 3);
        start_program = 1; prog_id = 1; tick(); clr_in();
        check("dup_busy", 32'(busy), 0);
        check("dup_cnt", 32'(active_count), 3);
        start_program = 1; prog_id = 0; tick(); clr_in();
        check("id0_fault", 32'(fault), 1);
        tick();
        check("fault_pulse", 32'(fault), 0);
        start_program = 1; prog_id = 5; tick(); clr_in();
        check("id5_fault", 32'(fault), 1);
        check("id5_cnt", 32'(active_count), 3);
        end_program = 1; tick(); clr_in();
        next_program = 1; tick(); clr_in();
        tick();
        check("end2_resched", 32'(cur_program), 3);
        check("end2_cnt2", 32'(active_count), 2);

        // Round robin {1,3} and saved PC
        do_next();
        check("rr_to1", 32'(cur_program), 1);
        do_spc(32'h40);
        do_next();
        check("rr_to3", 32'(cur_program), 3);
        do_next();
        check("rr_back1", 32'(cur_program), 1);
        lpc = 1; tick(); clr_in();
        check("lpc_40", q, 32'h40);

        // end + next together on slot 3
        do_next();
        do_spc(32'h33);
        check("mem600_set", dut.mem[600], 32'h33);
        end_program = 1; next_program = 1; tick(); clr_in();
        check("en_busy1", 32'(busy), 1);
        check("en_cnt", 32'(active_count), 1);
        tick();
        check("en_busy2", 32'(busy), 1);
        tick();
        check("en_idle", 32'(busy), 0);
        check("en_cur", 32'(cur_program), 1);
        check("mem600_clr", dut.mem[600], 0);

        // Last slot ends -> kernel; then end in kernel faults
        end_program = 1; tick(); clr_in(); tick(); tick();
        check("all_end_cur", 32'(cur_program), 0);
        check("all_end_cnt", 32'(active_count), 0);
        end_program = 1; tick(); clr_in();
        check("end0_fault", 32'(fault), 1);
        check("end0_cnt", 32'(active_count), 0);

        // Boundary access: offset 32+168 = 200 lands on word 400
        do_start(1);
        do_next();
        check("g_cur1", 32'(cur_program), 1);
        we = 1; endereco_escrita = 168; data = 32'hBB; tick(); clr_in();
`ifdef PARTITION_GUARD_EN
        check("g_fault", 32'(fault), 1);
        check("g_mem400", dut.mem[400], 0);
`else
        check("g_fault", 32'(fault), 0);
        check("g_mem400", dut.mem[400], 32'hBB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
